// File: rtl/alu_6502_pkg.sv
// Shared types and constants for the 6502 ALU sequencer: opcode classes,
// ALU mode encodings, flag bit positions and the sequencer state type.
package alu_6502_pkg;

  typedef enum logic [3:0] {
    OP_ORA = 4'h0,
    OP_AND = 4'h1,
    OP_EOR = 4'h2,
    OP_ADC = 4'h3,
    OP_SBC = 4'h4,
    OP_CMP = 4'h5,
    OP_INC = 4'h6,
    OP_DEC = 4'h7,
    OP_ASL = 4'h8,
    OP_LSR = 4'h9,
    OP_ROL = 4'hA,
    OP_ROR = 4'hB
  } op_t;

  typedef logic [2:0] alu_mode_t;

  localparam alu_mode_t MODE_OR   = 3'b000;
  localparam alu_mode_t MODE_AND  = 3'b001;
  localparam alu_mode_t MODE_EOR  = 3'b010;
  localparam alu_mode_t MODE_ADD  = 3'b011;
  localparam alu_mode_t MODE_SHL  = 3'b100;
  localparam alu_mode_t MODE_SHR  = 3'b101;
  localparam alu_mode_t MODE_IDLE = 3'b110;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Encodings C-F have no ALU meaning and are answered as illegal.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'hB;
  endfunction

endpackage

// File: rtl/alu_flags_6502.sv
// Combinational N/V/Z/C derivation, per-opcode flag write mask and
// result-write decision for one ALU operation.
module alu_flags_6502
  import alu_6502_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [8:0] r,
  output logic [3:0] flags,
  output logic [3:0] flag_we,
  output logic       wr_result
);

  logic [3:0] raw;
  logic [3:0] mask;

  always_comb begin
    raw            = '0;
    raw[FLAG_N]    = r[7];
    raw[FLAG_V]    = (a[7] == b[7]) && (r[7] != a[7]);
    raw[FLAG_Z]    = (r[7:0] == 8'h00);
    raw[FLAG_C]    = r[8];

    mask      = '0;
    wr_result = 1'b1;
    case (op_t'(op))
      OP_ORA, OP_AND, OP_EOR, OP_INC, OP_DEC: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_Z] = 1'b1;
      end
      OP_ADC, OP_SBC: begin
        mask = 4'b1111;
      end
      OP_CMP: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_C] = 1'b1;
        wr_result    = 1'b0;
      end
      OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_C] = 1'b1;
      end
      default: begin
        wr_result = 1'b0;
      end
    endcase

    // Flags outside the write mask are forced low so consumers never see stale values.
    flags   = raw & mask;
    flag_we = mask;
  end

endmodule

// File: rtl/alu_sequencer_6502.sv
// Request/response sequencer around the combinational 6502 ALU: decodes the
// opcode class into ALU inputs, holds them EXEC_CYCLES, registers result and flags.
module alu_sequencer_6502
  import alu_6502_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_m,
  input  logic       req_c,
  output logic [2:0] alu_mode,
  output logic [8:0] alu_a,
  output logic [8:0] alu_b,
  input  logic [8:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic [3:0] rsp_flag_we,
  output logic       rsp_wr_result,
  output logic       rsp_illegal
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_exec;
  logic             accept_illegal;

  logic [3:0] op_p0;
  logic [7:0] a_p0;
  logic [7:0] m_p0;
  logic       c_p0;

  alu_mode_t  mode_x;
  logic [8:0] a_x;
  logic [8:0] b_x;
  logic [7:0] b_eff;
  logic       shift;

  logic [3:0] flags_x;
  logic [3:0] flag_we_x;
  logic       wr_result_x;

  logic [7:0] rsp_data_p1;
  logic [3:0] rsp_flags_p1;
  logic [3:0] rsp_flag_we_p1;
  logic       rsp_wr_result_p1;
  logic       rsp_illegal_p1;

  // ---- stage 0: request latch (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      op_p0 <= req_op;
      a_p0  <= req_a;
      m_p0  <= req_m;
      c_p0  <= req_c;
    end
  end

  // Opcode to ALU mapping; b_eff is the operand the ALU actually sees (used for V).
  always_comb begin
    mode_x = MODE_IDLE;
    a_x    = {1'bx, a_p0};
    b_eff  = m_p0;
    shift  = 1'b0;
    case (op_t'(op_p0))
      OP_ORA: mode_x = MODE_OR;
      OP_AND: mode_x = MODE_AND;
      OP_EOR: mode_x = MODE_EOR;
      OP_ADC: begin
        mode_x = MODE_ADD;
        a_x    = {c_p0, a_p0};
      end
      OP_SBC: begin
        mode_x = MODE_ADD;
        a_x    = {c_p0, a_p0};
        b_eff  = ~m_p0;
      end
      OP_CMP: begin
        mode_x = MODE_ADD;
        a_x    = {1'b1, a_p0};
        b_eff  = ~m_p0;
      end
      OP_INC: begin
        mode_x = MODE_ADD;
        a_x    = {1'b0, a_p0};
        b_eff  = 8'h01;
      end
      OP_DEC: begin
        mode_x = MODE_ADD;
        a_x    = {1'b0, a_p0};
        b_eff  = 8'hFF;
      end
      OP_ASL, OP_LSR: begin
        mode_x = (op_p0 == OP_ASL) ? MODE_SHL : MODE_SHR;
        a_x    = {1'b0, a_p0};
        b_eff  = 8'h00;
        shift  = 1'b1;
      end
      OP_ROL, OP_ROR: begin
        mode_x = (op_p0 == OP_ROL) ? MODE_SHL : MODE_SHR;
        a_x    = {c_p0, a_p0};
        b_eff  = 8'h00;
        shift  = 1'b1;
      end
      default: mode_x = MODE_IDLE;
    endcase
    b_x = shift ? 9'bx : {1'bx, b_eff};
  end

  alu_flags_6502 u_flags (
    .op        (op_p0),
    .a         (a_p0),
    .b         (b_eff),
    .r         (alu_result),
    .flags     (flags_x),
    .flag_we   (flag_we_x),
    .wr_result (wr_result_x)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    alu_mode       = MODE_IDLE;
    alu_a          = 9'bx;
    alu_b          = 9'bx;
    last_exec      = 1'b0;
    accept_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_legal(req_op)) begin
            state_d = S_EXEC;
          end else begin
            state_d        = S_RESP;
            accept_illegal = 1'b1;
          end
        end
      end
      S_EXEC: begin
        alu_mode = mode_x;
        alu_a    = a_x;
        alu_b    = b_x;
        if (cnt_q == CNT_LAST) begin
          last_exec = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage 1: captured result and flags, held through the response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q            <= '0;
      rsp_data_p1      <= '0;
      rsp_flags_p1     <= '0;
      rsp_flag_we_p1   <= '0;
      rsp_wr_result_p1 <= 1'b0;
      rsp_illegal_p1   <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        cnt_q <= last_exec ? '0 : cnt_q + 1'b1;
      end
      if (last_exec) begin
        rsp_data_p1      <= alu_result[7:0];
        rsp_flags_p1     <= flags_x;
        rsp_flag_we_p1   <= flag_we_x;
        rsp_wr_result_p1 <= wr_result_x;
        rsp_illegal_p1   <= 1'b0;
      end else if (accept_illegal) begin
        rsp_data_p1      <= '0;
        rsp_flags_p1     <= '0;
        rsp_flag_we_p1   <= '0;
        rsp_wr_result_p1 <= 1'b0;
        rsp_illegal_p1   <= 1'b1;
      end
    end
  end

  assign rsp_data      = rsp_data_p1;
  assign rsp_flags     = rsp_flags_p1;
  assign rsp_flag_we   = rsp_flag_we_p1;
  assign rsp_wr_result = rsp_wr_result_p1;
  assign rsp_illegal   = rsp_illegal_p1;

endmodule

// File: tb/tb_alu_sequencer_6502.sv
// Directed bench for alu_sequencer_6502: two instances (EXEC_CYCLES 1 and 3),
// each driving a behavioural 6502 ALU model.
module tb_alu_sequencer_6502;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_m;
  logic       req_c;
  logic [2:0] alu_mode  [2];
  logic [8:0] alu_a     [2];
  logic [8:0] alu_b     [2];
  logic [8:0] alu_result[2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic [3:0] rsp_flags [2];
  logic [3:0] rsp_flag_we[2];
  logic       rsp_wr_result[2];
  logic       rsp_illegal[2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: OR/AND/EOR, add with a[8] as carry-in, shifts with a[8] as fill bit.
  function automatic logic [8:0] alu_model(input logic [2:0] mode, input logic [8:0] a,
                                           input logic [8:0] b);
    case (mode)
      3'b000:  return {1'b0, a[7:0] | b[7:0]};
      3'b001:  return {1'b0, a[7:0] & b[7:0]};
      3'b010:  return {1'b0, a[7:0] ^ b[7:0]};
      3'b011:  return {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, a[8]};
      3'b100:  return {a[7], a[6:0], a[8]};
      3'b101:  return {a[0], a[8], a[7:1]};
      default: return 9'h000;
    endcase
  endfunction

  assign alu_result[0] = alu_model(alu_mode[0], alu_a[0], alu_b[0]);
  assign alu_result[1] = alu_model(alu_mode[1], alu_a[1], alu_b[1]);

  alu_sequencer_6502 #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op), .req_a(req_a), .req_m(req_m), .req_c(req_c),
    .alu_mode(alu_mode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_result(alu_result[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_flags(rsp_flags[0]), .rsp_flag_we(rsp_flag_we[0]),
    .rsp_wr_result(rsp_wr_result[0]), .rsp_illegal(rsp_illegal[0])
  );

  alu_sequencer_6502 #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op), .req_a(req_a), .req_m(req_m), .req_c(req_c),
    .alu_mode(alu_mode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_result(alu_result[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_flags(rsp_flags[1]), .rsp_flag_we(rsp_flag_we[1]),
    .rsp_wr_result(rsp_wr_result[1]), .rsp_illegal(rsp_illegal[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current cycle, measure latency, check the response,
  // optionally stall it for `hold` cycles with a competing request, then consume it.
  task automatic run_op(input int sel, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] m, input logic c, input logic [2:0] exp_mode,
                        input logic [7:0] exp_data, input logic [3:0] exp_flags,
                        input logic [3:0] exp_we, input logic exp_wr, input logic exp_ill,
                        input int exp_lat, input int hold);
    int lat;
    check("req_ready_before", req_ready[sel], 1);
    req_op = op; req_a = a; req_m = m; req_c = c;
    req_valid[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    check("alu_mode_t1", alu_mode[sel], exp_mode);
    lat = 1;
    while (!rsp_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_data", rsp_data[sel], exp_data);
    check("rsp_flags", rsp_flags[sel], exp_flags);
    check("rsp_flag_we", rsp_flag_we[sel], exp_we);
    check("rsp_wr_result", rsp_wr_result[sel], exp_wr);
    check("rsp_illegal", rsp_illegal[sel], exp_ill);
    for (int i = 0; i < hold; i++) begin
      req_op = 4'h0; req_a = 8'h11; req_m = 8'h22; req_c = 1'b0;
      req_valid[sel] = 1'b1;
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid[sel], 1);
      check("hold_req_ready", req_ready[sel], 0);
      check("hold_rsp_data", rsp_data[sel], exp_data);
      check("hold_rsp_flags", rsp_flags[sel], exp_flags);
    end
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    check("after_hs_rsp_valid", rsp_valid[sel], 0);
    check("after_hs_req_ready", req_ready[sel], 1);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    req_op = 4'h0; req_a = 8'h00; req_m = 8'h00; req_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready[0], 1);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_rsp_data", rsp_data[0], 0);
    check("rst_rsp_flags", rsp_flags[0], 0);
    check("rst_rsp_flag_we", rsp_flag_we[0], 0);
    check("rst_rsp_wr", rsp_wr_result[0], 0);
    check("rst_rsp_illegal", rsp_illegal[0], 0);
    check("rst_alu_mode", alu_mode[0], 3'b110);
    reset_n = 1'b1;
    @(posedge clk); #1;

    //     sel op     A      M      C     mode    data   NVZC     we       wr ill lat hold
    run_op(0, 4'h3, 8'h50, 8'h50, 1'b0, 3'b011, 8'hA0, 4'b1100, 4'b1111, 1, 0, 2, 0); // ADC
    run_op(0, 4'h4, 8'h00, 8'h01, 1'b1, 3'b011, 8'hFF, 4'b1000, 4'b1111, 1, 0, 2, 0); // SBC
    run_op(0, 4'h5, 8'h40, 8'h40, 1'b0, 3'b011, 8'h00, 4'b0011, 4'b1011, 0, 0, 2, 0); // CMP
    run_op(0, 4'hB, 8'h01, 8'h00, 1'b1, 3'b101, 8'h80, 4'b1001, 4'b1011, 1, 0, 2, 0); // ROR
    run_op(0, 4'h8, 8'h80, 8'h00, 1'b0, 3'b100, 8'h00, 4'b0011, 4'b1011, 1, 0, 2, 0); // ASL
    run_op(0, 4'h7, 8'h00, 8'h00, 1'b1, 3'b011, 8'hFF, 4'b1000, 4'b1010, 1, 0, 2, 0); // DEC
    run_op(0, 4'h6, 8'hFF, 8'h00, 1'b0, 3'b011, 8'h00, 4'b0010, 4'b1010, 1, 0, 2, 0); // INC
    run_op(0, 4'hA, 8'h80, 8'h00, 1'b0, 3'b100, 8'h00, 4'b0011, 4'b1011, 1, 0, 2, 0); // ROL
    run_op(0, 4'h9, 8'h03, 8'h00, 1'b1, 3'b101, 8'h01, 4'b0001, 4'b1011, 1, 0, 2, 0); // LSR
    run_op(0, 4'h2, 8'hFF, 8'h0F, 1'b0, 3'b010, 8'hF0, 4'b1000, 4'b1010, 1, 0, 2, 0); // EOR
    run_op(0, 4'h1, 8'h3C, 8'h0F, 1'b1, 3'b001, 8'h0C, 4'b0000, 4'b1010, 1, 0, 2, 0); // AND
    // Backpressure: response stalled 5 cycles while a second request is offered.
    run_op(0, 4'h3, 8'h7F, 8'h01, 1'b0, 3'b011, 8'h80, 4'b1100, 4'b1111, 1, 0, 2, 5);

    // Reset during EXEC aborts without a response.
    req_op = 4'h3; req_a = 8'h12; req_m = 8'h34; req_c = 1'b0;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("exec_before_reset", alu_mode[0], 3'b011);
    reset_n = 1'b0;
    #1;
    check("async_rst_req_ready", req_ready[0], 1);
    check("async_rst_rsp_valid", rsp_valid[0], 0);
    #2;
    reset_n = 1'b1;
    rsp_ready[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid[0], 0);
      check("post_rst_req_ready", req_ready[0], 1);
    end
    rsp_ready[0] = 1'b0;
    run_op(0, 4'h0, 8'h0F, 8'hF0, 1'b0, 3'b000, 8'hFF, 4'b1000, 4'b1010, 1, 0, 2, 0); // ORA

    // Illegal opcode skips EXEC.
    run_op(0, 4'hE, 8'h55, 8'hAA, 1'b1, 3'b110, 8'h00, 4'b0000, 4'b0000, 0, 1, 1, 0);
    // Longer ALU hold time.
    run_op(1, 4'h3, 8'h50, 8'h50, 1'b0, 3'b011, 8'hA0, 4'b1100, 4'b1111, 1, 0, 4, 0);
    run_op(1, 4'h4, 8'h00, 8'h01, 1'b1, 3'b011, 8'hFF, 4'b1000, 4'b1111, 1, 0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
